// File: rtl/seq_mag_comp_ctrl_pkg.sv
// Shared types and helpers for the sequential magnitude comparator controller.
package seq_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // One-hot result encoding, ordered {G,E,L}
  localparam logic [2:0] RES_G = 3'b100;
  localparam logic [2:0] RES_E = 3'b010;
  localparam logic [2:0] RES_L = 3'b001;

  function automatic int cnt_w(input int width);
    return $clog2(width / 2 + 1);
  endfunction

endpackage

// File: rtl/seq_mag_comp_ctrl_cmp2_slice.sv
// Combinational 2-bit unsigned comparator; exactly one of G/E/L is high.
module cmp2_slice (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       G,
  output logic       E,
  output logic       L
);

  logic eq1, eq0;

  assign eq1 = a[1] ~^ b[1];
  assign eq0 = a[0] ~^ b[0];
  assign E   = eq1 & eq0;
  assign G   = (a[1] & ~b[1]) | (eq1 & a[0] & ~b[0]);
  assign L   = ~G & ~E;

endmodule

// File: rtl/seq_mag_comp_ctrl.sv
// MSB-first WIDTH-bit comparator built on one time-multiplexed 2-bit slice.
// Define CMP_EARLY_EXIT_EN to stop at the first unequal slice; otherwise all slices always run.
module seq_mag_comp_ctrl
  import seq_cmp_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             G,
  output logic             E,
  output logic             L,
  output logic [CW-1:0]    res_cnt,
  output logic             busy
);

  localparam int SLICES = WIDTH / 2;

  state_t           state, state_d;
  logic [WIDTH-1:0] a_r, b_r, a_d, b_d;
  logic [CW-1:0]    idx, idx_d, cnt, cnt_d, res_cnt_d;
  logic [2:0]       gel, gel_d, slice_res;
  logic             res_valid_d;
  logic [1:0]       a_sl, b_sl;
  logic             sg, se, sl;
`ifndef CMP_EARLY_EXIT_EN
  logic             decided, decided_d;
  logic [2:0]       dec, dec_d;
`endif

  assign a_sl = 2'(a_r >> {idx, 1'b0});
  assign b_sl = 2'(b_r >> {idx, 1'b0});

  cmp2_slice u_slice (.a(a_sl), .b(b_sl), .G(sg), .E(se), .L(sl));

  assign slice_res   = {sg, se, sl};
  assign start_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign {G, E, L}   = gel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d     = state;
    a_d         = a_r;
    b_d         = b_r;
    idx_d       = idx;
    cnt_d       = cnt;
    gel_d       = gel;
    res_cnt_d   = res_cnt;
    res_valid_d = res_valid;
`ifndef CMP_EARLY_EXIT_EN
    decided_d   = decided;
    dec_d       = dec;
`endif
    case (state)
      IDLE: begin
        if (start_valid) begin
          a_d       = a;
          b_d       = b;
          idx_d     = CW'(SLICES - 1);
          cnt_d     = '0;
          gel_d     = '0;
          res_cnt_d = '0;
`ifndef CMP_EARLY_EXIT_EN
          decided_d = 1'b0;
          dec_d     = '0;
`endif
          state_d   = COMPARE;
        end
      end
      COMPARE: begin
        cnt_d = cnt + 1'b1;
`ifdef CMP_EARLY_EXIT_EN
        if (!se) begin
          gel_d       = slice_res;
          res_cnt_d   = cnt + 1'b1;
          res_valid_d = 1'b1;
          state_d     = DONE;
        end else if (idx == '0) begin
          gel_d       = RES_E;
          res_cnt_d   = CW'(SLICES);
          res_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d = idx - 1'b1;
        end
`else
        // First unequal slice wins; lower slices are walked but ignored
        if (!decided && !se) begin
          decided_d = 1'b1;
          dec_d     = slice_res;
        end
        if (idx == '0) begin
          gel_d       = decided ? dec : slice_res;
          res_cnt_d   = CW'(SLICES);
          res_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d = idx - 1'b1;
        end
`endif
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r       <= '0;
      b_r       <= '0;
      idx       <= '0;
      cnt       <= '0;
      gel       <= '0;
      res_cnt   <= '0;
      res_valid <= 1'b0;
`ifndef CMP_EARLY_EXIT_EN
      decided   <= 1'b0;
      dec       <= '0;
`endif
    end else begin
      a_r       <= a_d;
      b_r       <= b_d;
      idx       <= idx_d;
      cnt       <= cnt_d;
      gel       <= gel_d;
      res_cnt   <= res_cnt_d;
      res_valid <= res_valid_d;
`ifndef CMP_EARLY_EXIT_EN
      decided   <= decided_d;
      dec       <= dec_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_mag_comp_ctrl.sv
// Directed bench for seq_mag_comp_ctrl (WIDTH=8) plus an exhaustive WIDTH=4 sweep.
module tb_seq_mag_comp_ctrl;

`ifdef CMP_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic       clk, rst_n;
  logic       start_valid, start_ready, res_valid, res_ready;
  logic [7:0] a, b;
  logic       G, E, L, busy;
  logic [2:0] res_cnt;

  logic       sv4, sr4, rv4, rr4, g4, e4, l4, busy4;
  logic [3:0] a4, b4;
  logic [1:0] rc4;

  int total, passed;

  seq_mag_comp_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .a(a), .b(b), .res_valid(res_valid), .res_ready(res_ready),
    .G(G), .E(E), .L(L), .res_cnt(res_cnt), .busy(busy));

  seq_mag_comp_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv4), .start_ready(sr4),
    .a(a4), .b(b4), .res_valid(rv4), .res_ready(rr4),
    .G(g4), .E(e4), .L(l4), .res_cnt(rc4), .busy(busy4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Waits for res_valid; k = cycles after the capture edge, -1 on timeout
  task automatic wait_res(output int k);
    k = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (res_valid) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic start_pair(input logic [7:0] ta, input logic [7:0] tb);
    a = ta; b = tb; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
  endtask

  task automatic release_res;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    total++;
    if ({start_ready, busy, res_valid, G, E, L, res_cnt} !== {1'b1, 1'b0, 1'b0, 3'b000, 3'd0})
      $display("FAIL reset_outputs got sr=%b busy=%b rv=%b gel=%b%b%b cnt=%0d want sr=1 busy=0 rv=0 gel=000 cnt=0",
               start_ready, busy, res_valid, G, E, L, res_cnt);
    else passed++;
    #10 rst_n = 1'b1;
    tick();
    total++;
    if (start_ready !== 1'b1) $display("FAIL reset_idle got start_ready=%b want 1", start_ready);
    else passed++;
  endtask

  task automatic test_equal;
    int k;
    start_pair(8'hA5, 8'hA5);
    total++;
    if (busy !== 1'b1 || res_valid !== 1'b0)
      $display("FAIL eq_compare_state got busy=%b rv=%b want busy=1 rv=0", busy, res_valid);
    else passed++;
    wait_res(k);
    total++;
    if (k !== 4) $display("FAIL eq_latency got %0d want 4", k); else passed++;
    total++;
    if ({G, E, L} !== 3'b010 || res_cnt !== 3'd4)
      $display("FAIL eq_result got gel=%b%b%b cnt=%0d want gel=010 cnt=4", G, E, L, res_cnt);
    else passed++;
    release_res();
    total++;
    if (res_valid !== 1'b0 || start_ready !== 1'b1 || {G, E, L} !== 3'b010)
      $display("FAIL eq_release got rv=%b sr=%b gel=%b%b%b want rv=0 sr=1 gel=010",
               res_valid, start_ready, G, E, L);
    else passed++;
  endtask

  task automatic test_greater;
    int k;
    start_pair(8'hC0, 8'h3F);
    wait_res(k);
    total++;
    if (k !== (EE ? 1 : 4)) $display("FAIL gt_latency got %0d want %0d", k, EE ? 1 : 4);
    else passed++;
    total++;
    if ({G, E, L} !== 3'b100 || res_cnt !== (EE ? 3'd1 : 3'd4))
      $display("FAIL gt_result got gel=%b%b%b cnt=%0d want gel=100 cnt=%0d", G, E, L, res_cnt, EE ? 1 : 4);
    else passed++;
    release_res();
  endtask

  task automatic test_less;
    int k;
    start_pair(8'h12, 8'h13);
    wait_res(k);
    total++;
    if ({G, E, L} !== 3'b001 || res_cnt !== 3'd4 || k !== 4)
      $display("FAIL lt_low_slice got gel=%b%b%b cnt=%0d k=%0d want gel=001 cnt=4 k=4", G, E, L, res_cnt, k);
    else passed++;
    release_res();
    start_pair(8'h00, 8'hFF);
    wait_res(k);
    total++;
    if ({G, E, L} !== 3'b001 || res_cnt !== (EE ? 3'd1 : 3'd4) || k !== (EE ? 1 : 4))
      $display("FAIL lt_top_slice got gel=%b%b%b cnt=%0d k=%0d want gel=001 cnt=%0d", G, E, L, res_cnt, k, EE ? 1 : 4);
    else passed++;
    release_res();
  endtask

  task automatic test_backpressure;
    int k;
    start_pair(8'hF0, 8'h0F);
    wait_res(k);
    a = 8'h00; b = 8'hFF; start_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({res_valid, start_ready, G, E, L} !== 5'b10100 || res_cnt !== (EE ? 3'd1 : 3'd4))
        $display("FAIL bp_hold[%0d] got rv=%b sr=%b gel=%b%b%b cnt=%0d want rv=1 sr=0 gel=100 cnt=%0d",
                 i, res_valid, start_ready, G, E, L, res_cnt, EE ? 1 : 4);
      else passed++;
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    total++;
    if (start_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0)
      $display("FAIL bp_bubble got sr=%b busy=%b rv=%b want sr=1 busy=0 rv=0", start_ready, busy, res_valid);
    else passed++;
    tick();
    start_valid = 1'b0;
    total++;
    if (busy !== 1'b1) $display("FAIL bp_capture got busy=%b want 1", busy); else passed++;
    wait_res(k);
    total++;
    if ({G, E, L} !== 3'b001 || k !== (EE ? 1 : 4))
      $display("FAIL bp_new_result got gel=%b%b%b k=%0d want gel=001 k=%0d", G, E, L, k, EE ? 1 : 4);
    else passed++;
    release_res();
  endtask

  task automatic test_async_reset;
    start_pair(8'hA5, 8'hA5);
    tick();
    total++;
    if (busy !== 1'b1) $display("FAIL rst_precond got busy=%b want 1", busy); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({start_ready, busy, res_valid, G, E, L, res_cnt} !== {1'b1, 1'b0, 1'b0, 3'b000, 3'd0})
      $display("FAIL rst_mid_compare got sr=%b busy=%b rv=%b gel=%b%b%b cnt=%0d want sr=1 busy=0 rv=0 gel=000 cnt=0",
               start_ready, busy, res_valid, G, E, L, res_cnt);
    else passed++;
    #2 rst_n = 1'b1;
    tick();
    total++;
    if (start_ready !== 1'b1 || res_valid !== 1'b0)
      $display("FAIL rst_release got sr=%b rv=%b want sr=1 rv=0", start_ready, res_valid);
    else passed++;
    begin
      int k;
      start_pair(8'h01, 8'h02);
      wait_res(k);
      total++;
      if ({G, E, L} !== 3'b001 || res_cnt !== 3'd4 || k !== 4)
        $display("FAIL rst_fresh got gel=%b%b%b cnt=%0d k=%0d want gel=001 cnt=4 k=4", G, E, L, res_cnt, k);
      else passed++;
    end
    release_res();
  endtask

  task automatic test_back_to_back;
    logic [15:0] pairs [3];
    logic [2:0]  exp   [3];
    int k;
    pairs[0] = 16'hFF00; exp[0] = 3'b100;
    pairs[1] = 16'h00FF; exp[1] = 3'b001;
    pairs[2] = 16'h5A5A; exp[2] = 3'b010;
    res_ready = 1'b1;
    start_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      {a, b} = pairs[i];
      total++;
      if (start_ready !== 1'b1) $display("FAIL b2b_idle[%0d] got sr=%b want 1", i, start_ready);
      else passed++;
      tick();
      total++;
      if (busy !== 1'b1) $display("FAIL b2b_capture[%0d] got busy=%b want 1", i, busy);
      else passed++;
      wait_res(k);
      total++;
      if ({G, E, L} !== exp[i])
        $display("FAIL b2b_result[%0d] got gel=%b%b%b want %b k=%0d", i, G, E, L, exp[i], k);
      else passed++;
      tick();
    end
    start_valid = 1'b0;
    res_ready = 1'b0;
  endtask

  task automatic test_sweep_w4;
    int bad, got;
    logic [2:0] want;
    bad = 0;
    rr4 = 1'b0;
    for (int i = 0; i < 256; i++) begin
      a4 = 4'(i / 16); b4 = 4'(i % 16);
      want = (a4 > b4) ? 3'b100 : (a4 == b4) ? 3'b010 : 3'b001;
      sv4 = 1'b1;
      tick();
      sv4 = 1'b0;
      got = 0;
      for (int c = 0; c < 10 && !got; c++) begin
        tick();
        if (rv4) got = 1;
      end
      total++;
      if (!got || {g4, e4, l4} !== want) begin
        $display("FAIL sweep4 a=%0d b=%0d got gel=%b%b%b valid=%0d want %b", a4, b4, g4, e4, l4, got, want);
        bad++;
      end else passed++;
      rr4 = 1'b1;
      tick();
      rr4 = 1'b0;
      if (bad > 8) break;
    end
  endtask

  initial begin
    total = 0; passed = 0;
    rst_n = 1'b0;
    start_valid = 1'b0; res_ready = 1'b0; a = '0; b = '0;
    sv4 = 1'b0; rr4 = 1'b0; a4 = '0; b4 = '0;
    test_reset();
    test_equal();
    test_greater();
    test_less();
    test_backpressure();
    test_async_reset();
    test_back_to_back();
    test_sweep_w4();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
